// File: rtl/lpf_spi_tx_if.sv
// Settings and serial-link bundle between the LPF register block and the serializer.
interface lpf_spi_tx_if;
    logic       pd;
    logic [7:0] fc;
    logic       resend;
    logic       sclk;
    logic       sdata;
    logic       sen_n;
    logic       busy;
    logic       done;

    modport master (
        output pd, fc, resend,
        input  sclk, sdata, sen_n, busy, done
    );

    modport slave (
        input  pd, fc, resend,
        output sclk, sdata, sen_n, busy, done
    );
endinterface

// File: rtl/lpf_spi_tx.sv
// Serializes the LPF {pd, fc} setting into a 9-bit SPI-like frame whenever
// the setting differs from what was last sent, or on an explicit resend.
// All link outputs decode straight from registered state, so an asserted
// reset clears them immediately.
module lpf_spi_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    lpf_spi_tx_if.slave  bus
);
    localparam int             CW  = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]  HM1 = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t      state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic        phase, phase_d;     // 1 = sclk high half of a bit
    logic [3:0]  nbits, nbits_d;     // completed sclk high phases
    logic [8:0]  shreg, shreg_d;
    logic [8:0]  sent, sent_d;
    logic        pending, pending_d;

    logic [8:0]  frame;
    logic        last;
    logic        start;
    logic        active;

    assign frame  = {bus.pd, bus.fc};
    assign last   = (cnt == HM1);
    assign start  = (state == IDLE) && (pending || bus.resend || (frame != sent));
    assign active = (state == SETUP) || (state == SHIFT);

    assign bus.sclk  = (state == SHIFT) && phase;
    assign bus.sen_n = !active;
    assign bus.sdata = active && shreg[8];
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == GAP) && (cnt == '0);

    // State and datapath registers; reset forces a full frame via pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            phase   <= 1'b0;
            nbits   <= '0;
            shreg   <= '0;
            sent    <= '0;
            pending <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            phase   <= phase_d;
            nbits   <= nbits_d;
            shreg   <= shreg_d;
            sent    <= sent_d;
            pending <= pending_d;
        end
    end

    // Next-state: frame sequencing, half-period timing and change tracking.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CW'(1);
        phase_d   = phase;
        nbits_d   = nbits;
        shreg_d   = shreg;
        sent_d    = sent;
        // A resend arriving mid-frame is remembered; a second one is absorbed.
        pending_d = pending || bus.resend;

        case (state)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d   = SETUP;
                    shreg_d   = frame;
                    sent_d    = frame;
                    pending_d = 1'b0;
                end
            end
            SETUP: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                    phase_d = 1'b1;
                    nbits_d = '0;
                end
            end
            SHIFT: begin
                if (last) begin
                    cnt_d = '0;
                    if (phase) begin
                        // Falling sclk: advance data so it is settled long
                        // before the next rising edge.
                        phase_d = 1'b0;
                        shreg_d = {shreg[7:0], 1'b0};
                        nbits_d = nbits + 4'd1;
                    end else if (nbits == 4'd9) begin
                        state_d = GAP;
                    end else begin
                        phase_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_lpf_spi_tx.sv
// Directed/randomized bench for lpf_spi_tx: a passive monitor turns each busy
// window into a frame record; the main sequence predicts frames from the
// setting-change rules and compares.
module tb_lpf_spi_tx;
    logic       clk = 1'b0;
    logic [1:0] rsts = 2'b11;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    lpf_spi_tx_if ifa ();
    lpf_spi_tx_if ifb ();

    lpf_spi_tx #(.CLK_DIV(2)) dut_a (.clk(clk), .rst(rsts[0]), .bus(ifa.slave));
    lpf_spi_tx #(.CLK_DIV(1)) dut_b (.clk(clk), .rst(rsts[1]), .bus(ifb.slave));

    logic [1:0] o_sclk, o_sdata, o_sen_n, o_busy, o_done;
    assign o_sclk  = {ifb.sclk,  ifa.sclk};
    assign o_sdata = {ifb.sdata, ifa.sdata};
    assign o_sen_n = {ifb.sen_n, ifa.sen_n};
    assign o_busy  = {ifb.busy,  ifa.busy};
    assign o_done  = {ifb.done,  ifa.done};

    typedef struct {
        int         dut;
        logic [8:0] bits;
        int         nb;
        int         low;
        int         busy;
        int         dones;
    } frame_t;

    frame_t     fq[$];
    int         mon_nb[2], mon_low[2], mon_busy[2], mon_done[2];
    logic [8:0] mon_bits[2];
    logic       prev_sclk[2], prev_sdata[2];
    int         stab_err[2], idle_err[2];

    // Monitor: one sample per cycle, collect a frame per busy window.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rsts[k]) begin
                mon_nb[k] = 0; mon_low[k] = 0; mon_busy[k] = 0;
                mon_done[k] = 0; mon_bits[k] = '0;
            end else begin
                if (o_sen_n[k] && (o_sdata[k] || o_sclk[k])) idle_err[k]++;
                if (!o_busy[k] && o_done[k]) idle_err[k]++;
                if (o_busy[k]) begin
                    mon_busy[k]++;
                    if (!o_sen_n[k]) mon_low[k]++;
                    if (o_done[k]) mon_done[k]++;
                    if (o_sclk[k] && !prev_sclk[k]) begin
                        mon_nb[k]++;
                        mon_bits[k] = {mon_bits[k][7:0], o_sdata[k]};
                        if (o_sdata[k] != prev_sdata[k]) stab_err[k]++;
                    end
                end else if (mon_busy[k] != 0) begin
                    fq.push_back('{k, mon_bits[k], mon_nb[k], mon_low[k], mon_busy[k], mon_done[k]});
                    mon_nb[k] = 0; mon_low[k] = 0; mon_busy[k] = 0;
                    mon_done[k] = 0; mon_bits[k] = '0;
                end
            end
            prev_sclk[k]  = o_sclk[k];
            prev_sdata[k] = o_sdata[k];
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_frame_start(input int k, input string tag);
        int t;
        t = 0;
        while (o_sen_n[k] !== 1'b0 && t < 300) begin
            run(1);
            t++;
        end
        chk({tag, "_start_timeout"}, int'(t < 300), 1);
    endtask

    // Pops every recorded frame of one DUT and compares against up to two predictions.
    task automatic expect_frames(input int k, input int n, input logic [8:0] v0,
                                 input logic [8:0] v1, input int h, input string tag);
        frame_t got[$];
        frame_t f;
        logic [8:0] ev;
        got = {};
        while (fq.size() > 0) begin
            f = fq.pop_front();
            if (f.dut == k) got.push_back(f);
        end
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            ev = (i == 0) ? v0 : v1;
            chk({tag, "_bits"},  int'(got[i].bits), int'(ev));
            chk({tag, "_edges"}, got[i].nb,   9);
            chk({tag, "_sen_low"}, got[i].low, 19 * h);
            chk({tag, "_busy"},  got[i].busy, 20 * h);
            chk({tag, "_done"},  got[i].dones, 1);
        end
    endtask

    task automatic pulse_resend;
        ifa.resend = 1'b1;
        run(1);
        ifa.resend = 1'b0;
    endtask

    logic [8:0] model_sent;
    logic [8:0] v, s, a, b;
    int         nexp;
    bit         rs;
    int         t;

    initial begin
        ifa.pd = 1'b0; ifa.fc = 8'h00; ifa.resend = 1'b0;
        ifb.pd = 1'b0; ifb.fc = 8'hFF; ifb.resend = 1'b0;
        for (int k = 0; k < 2; k++) begin
            stab_err[k] = 0; idle_err[k] = 0; prev_sclk[k] = 1'b0; prev_sdata[k] = 1'b0;
        end
        run(3);

        // Reset values
        chk("rst_sclk",  int'(ifa.sclk),  0);
        chk("rst_sdata", int'(ifa.sdata), 0);
        chk("rst_sen_n", int'(ifa.sen_n), 1);
        chk("rst_busy",  int'(ifa.busy),  0);
        chk("rst_done",  int'(ifa.done),  0);

        // First frame after release: forced by pending even though {pd,fc} == 0
        rsts[0] = 1'b0;
        run(1);
        chk("post_rst_start_sen_n", int'(ifa.sen_n), 0);
        run(120);
        expect_frames(0, 1, 9'h000, 9'h000, 2, "first");
        model_sent = 9'h000;

        // Idle change to 1A5
        ifa.pd = 1'b1; ifa.fc = 8'hA5;
        run(120);
        expect_frames(0, 1, 9'h1A5, 9'h000, 2, "a5");
        model_sent = 9'h1A5;

        // Two changes during a frame coalesce into one follow-on frame
        ifa.fc = 8'h3C;
        wait_frame_start(0, "coal");
        run(5);
        ifa.fc = 8'h10;
        run(3);
        ifa.fc = 8'h22;
        run(250);
        expect_frames(0, 2, 9'h13C, 9'h122, 2, "coal");
        model_sent = 9'h122;

        // Quiet idle, then a lone resend repeats the same data
        run(200);
        expect_frames(0, 0, 9'h000, 9'h000, 2, "quiet");
        chk("quiet_sen_n", int'(ifa.sen_n), 1);
        chk("quiet_sclk",  int'(ifa.sclk),  0);
        pulse_resend();
        run(150);
        expect_frames(0, 1, model_sent, 9'h000, 2, "resend");

        // Reset mid-frame after the 4th rising sclk, with all-zero settings
        ifa.pd = 1'b0; ifa.fc = 8'h00;
        wait_frame_start(0, "abort");
        t = 0;
        while (mon_nb[0] < 4 && t < 200) begin
            run(1);
            t++;
        end
        chk("abort_edge_timeout", int'(t < 200), 1);
        rsts[0] = 1'b1;
        #1;
        chk("abort_sclk",  int'(ifa.sclk),  0);
        chk("abort_sdata", int'(ifa.sdata), 0);
        chk("abort_sen_n", int'(ifa.sen_n), 1);
        chk("abort_busy",  int'(ifa.busy),  0);
        chk("abort_done",  int'(ifa.done),  0);
        run(3);
        rsts[0] = 1'b0;
        run(150);
        expect_frames(0, 1, 9'h000, 9'h000, 2, "abort");
        model_sent = 9'h000;

        // Random idle changes; one repeats the last sent value (no frame expected)
        for (int i = 0; i < 6; i++) begin
            v = (i == 2) ? model_sent : 9'($urandom);
            {ifa.pd, ifa.fc} = v;
            run(120);
            nexp = (v != model_sent) ? 1 : 0;
            expect_frames(0, nexp, v, 9'h000, 2, "rand_idle");
            model_sent = v;
        end

        // Random mid-frame changes, sometimes with a double resend
        for (int i = 0; i < 4; i++) begin
            s = model_sent ^ 9'(1 + $urandom_range(0, 510));
            a = 9'($urandom);
            b = (i == 1) ? s : 9'($urandom);
            rs = (i % 2) == 1;
            {ifa.pd, ifa.fc} = s;
            wait_frame_start(0, "rand_mid");
            run($urandom_range(1, 20));
            {ifa.pd, ifa.fc} = a;
            if (rs) begin
                pulse_resend();
                run(1);
                pulse_resend();
            end
            run(2);
            {ifa.pd, ifa.fc} = b;
            run(250);
            nexp = (b != s || rs) ? 2 : 1;
            expect_frames(0, nexp, s, b, 2, "rand_mid");
            model_sent = b;
        end

        // CLK_DIV=1 instance: 0FF frame right after reset
        rsts[1] = 1'b0;
        run(40);
        expect_frames(1, 1, 9'h0FF, 9'h000, 1, "div1");

        chk("stab_a",  stab_err[0], 0);
        chk("stab_b",  stab_err[1], 0);
        chk("idle_a",  idle_err[0], 0);
        chk("idle_b",  idle_err[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lpf_spi_tx.md
LPF_SPI_TX -- requirements
Module: lpf_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning SCLK half-period in clk cycles (H = CLK_DIV, legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pd  input  1  LPF power-down setting from the LPF control register block.
REQ-005 SHALL have port fc  input  8  LPF cutoff code from the LPF control register block.
REQ-006 SHALL have port resend  input  1  single-cycle request to retransmit current settings.
REQ-007 SHALL have port sclk  output  1  serial clock to the analog LPF; idle low.
REQ-008 SHALL have port sdata  output  1  serial data, MSB first.
REQ-009 SHALL have port sen_n  output  1  frame enable, active-low.
REQ-010 SHALL have port busy  output  1  high while a frame or inter-frame gap is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 SHALL transmit a 9-bit frame {pd, fc[7:0]}, bit 8 first; pd and fc are sampled only in the cycle a frame starts.
REQ-013 SHALL keep a sent register holding the last transmitted frame and a pending flag.
REQ-014 SHALL start a frame from IDLE when pending=1, resend=1, or {pd,fc} != sent; pending clears at frame start.
REQ-015 SHALL implement the states IDLE -> SETUP -> SHIFT -> GAP -> IDLE, with a half-period counter of ceil(log2(CLK_DIV+1)) bits.
REQ-016 SHALL, on the start cycle t: load the shift register, update sent, and from t+1 drive sen_n=0, busy=1, sdata=bit 8, sclk=0; state is SETUP.
REQ-017 SETUP SHALL last H cycles, then enter SHIFT.
REQ-018 SHIFT SHALL, for each of 9 bits, drive sclk high for H cycles and then low for H cycles; sdata changes only on the sclk falling edge and is stable across each rising edge.
REQ-019 SHALL drive sen_n high and pulse done for exactly one cycle after the 9th low phase; total sen_n low time is 19H cycles.
REQ-020 GAP SHALL hold sen_n=1, sclk=0, busy=1 for H cycles; busy then falls and the state returns to IDLE.
REQ-021 SHALL leave sdata at 0 whenever sen_n=1.
REQ-022 SHALL sample pd/fc/resend changes during a frame as follows: a change to pd/fc leaves {pd,fc} != sent, and a resend pulse sets pending; either causes exactly one further frame after GAP.
REQ-023 SHALL coalesce multiple changes during one frame into a single follow-on frame carrying the latest values.
REQ-024 SHALL ignore resend while pending=1 (no double counting).
REQ-025 SHALL start no frame while in IDLE when {pd,fc} == sent, pending=0 and resend=0.

Reset
REQ-026 On rst=1, SHALL immediately set sclk=0, sdata=0, sen_n=1, busy=0, done=0, state=IDLE, sent=9'h000, pending=1.
REQ-027 SHALL abort any frame in progress on reset without completing SCLK edges; the pending flag then forces a full frame after reset is released.
REQ-028 SHALL start the first post-reset frame on the first clk edge with rst=0.

Verification
REQ-029 Scenario: CLK_DIV=2, release reset with pd=0 and fc=0 -> one frame with 9 rising sclk edges all carrying 0, sen_n low 38 cycles, a single done pulse, busy high 40 cycles, then idle.
REQ-030 Scenario: after idle, set pd=1 and fc=8'hA5 -> a frame whose bits sampled at rising edges are 1,1,0,1,0,0,1,0,1, and sent=9'h1A5.
REQ-031 Scenario: during a frame, set fc=8'h10 and then fc=8'h22 -> the current frame completes unchanged, followed by exactly one frame carrying {pd,8'h22}, and no third frame.
REQ-032 Scenario: idle with unchanged inputs for 200 cycles -> sen_n stays 1 and sclk stays 0; a single resend pulse -> exactly one frame with identical data.
REQ-033 Scenario: assert rst after the 4th rising sclk edge -> outputs return to reset values in the same cycle; after release, a complete 9-bit frame follows.
REQ-034 Scenario: CLK_DIV=1 with fc=8'hFF and pd=0 -> sclk toggles every cycle, sen_n low 19 cycles, and bits 0,1,1,1,1,1,1,1,1.
